// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, FSM encoding and frame field positions for the SPI command decoder.
package spi_cmd_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_INIT   = 8'h01;
  localparam logic [7:0] OP_WR_INV = 8'h02;
  localparam logic [7:0] OP_RD_INV = 8'h03;
  localparam logic [7:0] OP_WR_LED = 8'h04;
  localparam logic [7:0] OP_RD_LED = 8'h05;

  localparam int OPC_LSB     = 0;
  localparam int PAYLOAD_LSB = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXEC    = 3'd1,
    ST_WAIT_WR = 3'd2,
    ST_ACK     = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_cmd_decoder.sv
// Decodes 32-bit SPI frames, executes opcodes against the inverted-data and LED
// registers, and returns 24-bit response words through the slave's write path.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int          WR_TIMEOUT = 1024,
  parameter logic [15:0] LED_RESET  = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_data_available,
  input  logic [31:0] rd_data,
  output logic        rd_ack,
  input  logic        wr_buffer_free,
  output logic        wr_en,
  output logic [23:0] wr_data,
  output logic [15:0] leds,
  output logic [15:0] cmd_count,
  output logic [7:0]  err_count,
  output logic        busy
);

  localparam int               TMO_W    = (WR_TIMEOUT > 1) ? $clog2(WR_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WR_TIMEOUT - 1);

  state_e           r_state, w_state_nxt;
  logic [23:0]      r_frame, w_frame_nxt;
  logic [15:0]      r_data, w_data_nxt;
  logic [15:0]      r_leds, w_leds_nxt;
  logic [15:0]      r_cmd_count, w_cmd_count_nxt;
  logic [7:0]       r_err_count, w_err_count_nxt;
  logic [23:0]      r_resp, w_resp_nxt;
  logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
  logic             r_wr_en, w_wr_en_nxt;
  logic [23:0]      r_wr_data, w_wr_data_nxt;
  logic             r_rd_ack, w_rd_ack_nxt;
  logic             r_busy;

  logic [7:0]  w_opc;
  logic [15:0] w_payload;
  // The top byte of a frame carries nothing for this stage.
  logic        w_unused_hi;

  assign w_opc       = r_frame[OPC_LSB +: 8];
  assign w_payload   = r_frame[PAYLOAD_LSB +: 16];
  assign w_unused_hi = ^rd_data[31:24];

  // State and datapath registers; every output is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_frame     <= 24'h000000;
      r_data      <= 16'h0000;
      r_leds      <= LED_RESET;
      r_cmd_count <= 16'h0000;
      r_err_count <= 8'h00;
      r_resp      <= 24'h000000;
      r_tmo       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= 24'h000000;
      r_rd_ack    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame     <= w_frame_nxt;
      r_data      <= w_data_nxt;
      r_leds      <= w_leds_nxt;
      r_cmd_count <= w_cmd_count_nxt;
      r_err_count <= w_err_count_nxt;
      r_resp      <= w_resp_nxt;
      r_tmo       <= w_tmo_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_rd_ack    <= w_rd_ack_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next-state and datapath update; pulses default low, everything else holds.
  always_comb begin
    w_state_nxt     = r_state;
    w_frame_nxt     = r_frame;
    w_data_nxt      = r_data;
    w_leds_nxt      = r_leds;
    w_cmd_count_nxt = r_cmd_count;
    w_err_count_nxt = r_err_count;
    w_resp_nxt      = r_resp;
    w_tmo_nxt       = r_tmo;
    w_wr_en_nxt     = 1'b0;
    w_wr_data_nxt   = r_wr_data;
    w_rd_ack_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (rd_data_available) begin
          w_frame_nxt = rd_data[23:0];
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: begin
        w_tmo_nxt       = '0;
        w_cmd_count_nxt = r_cmd_count + 16'd1;
        w_state_nxt     = ST_ACK;
        case (w_opc)
          OP_NOP:    w_data_nxt = r_data;
          OP_INIT:   w_data_nxt = 16'h0000;
          OP_WR_INV: w_data_nxt = ~w_payload;
          OP_RD_INV: begin
            w_resp_nxt  = {OP_RD_INV, r_data};
            w_state_nxt = ST_WAIT_WR;
          end
          OP_WR_LED: w_leds_nxt = w_payload;
          OP_RD_LED: begin
            w_resp_nxt  = {OP_RD_LED, r_leds};
            w_state_nxt = ST_WAIT_WR;
          end
          default: begin
            w_cmd_count_nxt = r_cmd_count;
            w_err_count_nxt = sat_inc8(r_err_count);
          end
        endcase
      end
      ST_WAIT_WR: begin
        if (wr_buffer_free) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_data_nxt = r_resp;
          w_state_nxt   = ST_ACK;
        end else if (r_tmo == TMO_LAST) begin
          w_err_count_nxt = sat_inc8(r_err_count);
          w_state_nxt     = ST_ACK;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      ST_ACK: begin
        w_rd_ack_nxt = 1'b1;
        w_state_nxt  = ST_RELEASE;
      end
      ST_RELEASE: begin
        // Hold until the slave retires the frame so it is never decoded twice.
        if (!rd_data_available) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RELEASE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign rd_ack    = r_rd_ack;
  assign wr_en     = r_wr_en;
  assign wr_data   = r_wr_data;
  assign leds      = r_leds;
  assign cmd_count = r_cmd_count;
  assign err_count = r_err_count;
  assign busy      = r_busy;

endmodule
